// File: rtl/jk_ff_bank_sync.sv
// ----------------------------------------------------------------------------
// jk_ff_bank_sync
//
// Bank of CHANNELS independent JK-style flip-flops, modelled as fully
// synchronous logic in the Clk domain. Each channel's TTL-style clock Ck[i]
// is sampled as data, and an edge of Ck[i] is detected against the
// previous sample. Each channel has a per-channel mode (JK / T / D / hold)
// and active-low synchronous preset/clear. Clear has priority over preset.
//
// Parameters
//   CHANNELS     number of channels (1..16)
//   EDGE         0 = act on falling Ck[i], 1 = act on rising Ck[i]
//   RESET_VALUE  value loaded into Q by Reset
//
// Ports
//   Clk          system clock; all state updates on its rising edge
//   Reset        asynchronous, active-high reset
//   Cen          global clock enable; 0 freezes Q, Ck sample and Changed
//   Ck           per-channel flip-flop clock (sampled as data)
//   J, K         per-channel data inputs
//   Mode         per-channel mode [2i+1:2i]: 00 JK, 01 T, 10 D, 11 hold
//   Preset_bar   per-channel active-low synchronous preset
//   Clear_bar    per-channel active-low synchronous clear
//   Cascade      (only with JK_FF_BANK_SYNC_CASCADE_EN) chain channels as a
//                ripple counter driven from channel 0
//   Q, Q_bar     flip-flop state and its complement
//   Changed      one-cycle pulse in the cycle after Q[i] changed
//
// Optional feature macro: JK_FF_BANK_SYNC_CASCADE_EN
// ----------------------------------------------------------------------------
module jk_ff_bank_sync #(
    parameter int                  CHANNELS    = 4,
    parameter int                  EDGE        = 0,
    parameter logic [CHANNELS-1:0] RESET_VALUE = '0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Cen,
    input  logic [CHANNELS-1:0]     Ck,
    input  logic [CHANNELS-1:0]     J,
    input  logic [CHANNELS-1:0]     K,
    input  logic [2*CHANNELS-1:0]   Mode,
    input  logic [CHANNELS-1:0]     Preset_bar,
    input  logic [CHANNELS-1:0]     Clear_bar,
`ifdef JK_FF_BANK_SYNC_CASCADE_EN
    input  logic                    Cascade,
`endif
    output logic [CHANNELS-1:0]     Q,
    output logic [CHANNELS-1:0]     Q_bar,
    output logic [CHANNELS-1:0]     Changed
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_T    = 2'b01;
    localparam logic [1:0] MODE_D    = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // Ck_prev resets to the idle level of the active edge so that a steady
    // Ck after reset never looks like an edge.
    localparam logic [CHANNELS-1:0] CK_PREV_RST = {CHANNELS{EDGE != 0}};

    logic [CHANNELS-1:0] q_q, q_d;
    logic [CHANNELS-1:0] ck_prev_q;
    logic [CHANNELS-1:0] changed_q, changed_d;
    logic [CHANNELS-1:0] ev_raw;     // edge detected on the channel's own Ck
    logic [CHANNELS-1:0] ev_eff;     // edge actually used (after cascade)
    logic                chain_ev;   // ripple from the previous channel

    // Channels are evaluated in order so that, in cascade mode, channel i
    // sees the next-state of channel i-1 computed earlier in the same pass;
    // the whole ripple therefore settles combinationally within one Clk.
    always_comb begin
        q_d      = q_q;
        ev_raw   = '0;
        ev_eff   = '0;
        chain_ev = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (EDGE != 0) begin
                ev_raw[i] = Cen & Ck[i] & ~ck_prev_q[i];
            end else begin
                ev_raw[i] = Cen & ~Ck[i] & ck_prev_q[i];
            end
            ev_eff[i] = ev_raw[i];
`ifdef JK_FF_BANK_SYNC_CASCADE_EN
            if (Cascade && (i > 0)) begin
                ev_eff[i] = chain_ev;
            end
`endif
            if (!Clear_bar[i]) begin
                q_d[i] = 1'b0;
            end else if (!Preset_bar[i]) begin
                q_d[i] = 1'b1;
            end else if (ev_eff[i]) begin
                case (Mode[2*i +: 2])
                    MODE_JK: begin
                        case ({J[i], K[i]})
                            2'b10:   q_d[i] = 1'b1;
                            2'b01:   q_d[i] = 1'b0;
                            2'b11:   q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    MODE_T:    q_d[i] = J[i] ? ~q_q[i] : q_q[i];
                    MODE_D:    q_d[i] = J[i];
                    MODE_HOLD: q_d[i] = q_q[i];
                    default:   q_d[i] = q_q[i];
                endcase
            end
            // The next channel in a cascade is clocked only when this
            // channel was itself clocked and its output makes the
            // active-edge transition (1->0 for falling, 0->1 for rising).
            if (EDGE != 0) begin
                chain_ev = ev_eff[i] & ~q_q[i] & q_d[i];
            end else begin
                chain_ev = ev_eff[i] & q_q[i] & ~q_d[i];
            end
        end
    end

    assign changed_d = q_d ^ q_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q_q       <= RESET_VALUE;
            ck_prev_q <= CK_PREV_RST;
            changed_q <= '0;
        end else if (Cen) begin
            q_q       <= q_d;
            ck_prev_q <= Ck;
            changed_q <= changed_d;
        end
    end

    assign Q       = q_q;
    assign Q_bar   = ~q_q;
    assign Changed = changed_q;

endmodule
